// File: rtl/seq_alu.sv
// Clocked EX-stage ALU: single-cycle base ops plus iterative unsigned MUL/MULHU/DIVU/REMU.
// IDLE | ready, base ops complete in one cycle ; BUSY | one mul/div bit per cycle, counter 0..WIDTH-1
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       Ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] Out,
  output logic             zero,
  output logic             slt,
  output logic             sltu
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d, lo_q, lo_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d, slt_q, slt_d, sltu_q, sltu_d, valid_q, valid_d;

  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] base_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_lo;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_acc, div_lo;
  logic [WIDTH-1:0] iter_res;

  assign shamt = B[CW-1:0];

  always_comb begin
    base_res = '0;
    case (Ctrl)
      4'd0:    base_res = A + B;
      4'd1:    base_res = A - B;
      4'd2:    base_res = A & B;
      4'd3:    base_res = A | B;
      4'd4:    base_res = A ^ B;
      4'd5:    base_res = A << shamt;
      4'd6:    base_res = $signed(A) >>> shamt;
      4'd7:    base_res = A >> shamt;
      default: base_res = '0;
    endcase
  end

  // Shift-add: {acc,lo} is the 2*WIDTH product register, multiplier starts in lo.
  always_comb begin
    mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    mul_acc = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // Restoring division: acc is the partial remainder, lo shifts dividend out / quotient in.
  // A zero divisor always "succeeds", giving an all-ones quotient and remainder = A.
  always_comb begin
    div_shift = {acc_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_ok    = (div_shift >= {1'b0, b_q});
    div_acc   = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], div_ok};
  end

  always_comb begin
    case (op_q)
      2'd0:    iter_res = mul_lo;
      2'd1:    iter_res = mul_acc;
      2'd2:    iter_res = div_lo;
      default: iter_res = div_acc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    out_d   = out_q;
    zero_d  = zero_q;
    slt_d   = slt_q;
    sltu_d  = sltu_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (Ctrl[3:2] == 2'b10) begin
            op_d    = Ctrl[1:0];
            a_d     = A;
            b_d     = B;
            acc_d   = '0;
            lo_d    = Ctrl[1] ? A : B;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            out_d   = base_res;
            zero_d  = (base_res == '0);
            slt_d   = $signed(A) < $signed(B);
            sltu_d  = A < B;
            valid_d = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d = op_q[1] ? div_acc : mul_acc;
        lo_d  = op_q[1] ? div_lo : mul_lo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          out_d   = iter_res;
          zero_d  = (iter_res == '0);
          slt_d   = $signed(a_q) < $signed(b_q);
          sltu_d  = a_q < b_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      zero_q  <= 1'b0;
      slt_q   <= 1'b0;
      sltu_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      slt_q   <= slt_d;
      sltu_q  <= sltu_d;
      valid_q <= valid_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign valid = valid_q;
  assign Out   = out_q;
  assign zero  = zero_q;
  assign slt   = slt_q;
  assign sltu  = sltu_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for single ops, hand sequences for multi-cycle cases.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  ctrl;
  logic [31:0] a, b;
  logic        ready, valid, zero, slt, sltu;
  logic [31:0] out;

  logic        start8;
  logic [3:0]  ctrl8;
  logic [7:0]  a8, b8;
  logic        ready8, valid8, zero8, slt8, sltu8;
  logic [7:0]  out8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Ctrl(ctrl), .A(a), .B(b),
    .ready(ready), .valid(valid), .Out(out), .zero(zero), .slt(slt), .sltu(sltu)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .Ctrl(ctrl8), .A(a8), .B(b8),
    .ready(ready8), .valid(valid8), .Out(out8), .zero(zero8), .slt(slt8), .sltu(sltu8)
  );

  typedef struct {
    string       nm;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_out;
    logic        exp_zero;
    logic        exp_slt;
    logic        exp_sltu;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int   cyc;
    logic seen;
    logic rdy_ok;
    @(negedge clk);
    ctrl = v.ctrl; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; seen = 1'b0; rdy_ok = 1'b1;
    while (!seen && cyc <= 100) begin
      if (valid) seen = 1'b1;
      else begin
        if (ready) rdy_ok = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({v.nm, " valid_seen"}, 32'(seen), 32'd1);
    check({v.nm, " latency"}, 32'(cyc), 32'(v.exp_lat));
    check({v.nm, " out"}, out, v.exp_out);
    check({v.nm, " zero"}, 32'(zero), 32'(v.exp_zero));
    check({v.nm, " slt"}, 32'(slt), 32'(v.exp_slt));
    check({v.nm, " sltu"}, 32'(sltu), 32'(v.exp_sltu));
    check({v.nm, " ready_at_valid"}, 32'(ready), 32'd1);
    check({v.nm, " ready_low_while_busy"}, 32'(rdy_ok), 32'd1);
    @(posedge clk); #1;
    check({v.nm, " single_valid"}, 32'(valid), 32'd0);
  endtask

  initial begin
    int          cyc;
    int          nval;
    logic [3:0]  bb_ctrl[4];
    logic [31:0] bb_b[4];
    logic [31:0] bb_exp[4];

    rst_n = 1'b0; start = 1'b0; ctrl = '0; a = '0; b = '0;
    start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst out", out, 32'd0);
    check("rst zero", 32'(zero), 32'd0);
    check("rst slt", 32'(slt), 32'd0);
    check("rst sltu", 32'(sltu), 32'd0);
    check("rst valid", 32'(valid), 32'd0);
    check("rst ready", 32'(ready), 32'd1);
    check("rst8 ready", 32'(ready8), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b1, 1'b0, 1});
    vecs.push_back('{"sra_shamt", 4'd6,  32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"sub_neg",   4'd1,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{"and",       4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{"sll31",     4'd5,  32'h1,         32'd31,        32'h8000_0000, 1'b0, 1'b1, 1'b1, 1});
    vecs.push_back('{"srl4",      4'd7,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"reserved",  4'd12, 32'd3,         32'd5,         32'h0,         1'b1, 1'b1, 1'b1, 1});
    vecs.push_back('{"mul",       4'd8,  32'h1_0000,    32'h1_0000,    32'h0,         1'b1, 1'b0, 1'b0, 33});
    vecs.push_back('{"mulhu",     4'd9,  32'h1_0000,    32'h1_0000,    32'h1,         1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"mul_big",   4'd8,  32'hFFFF_FFFF, 32'd3,         32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 33});
    vecs.push_back('{"divu",      4'd10, 32'd100,       32'd7,         32'd14,        1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"remu",      4'd11, 32'd100,       32'd7,         32'd2,         1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"divu_by0",  4'd10, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33});
    vecs.push_back('{"remu_by0",  4'd11, 32'd9,         32'd0,         32'd9,         1'b0, 1'b0, 1'b0, 33});
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Back-to-back base ops with start held high.
    bb_ctrl = '{4'd2, 4'd3, 4'd4, 4'd5};
    bb_b    = '{32'h00FF, 32'h00FF, 32'h00FF, 32'd4};
    bb_exp  = '{32'h000F, 32'h0FFF, 32'h0FF0, 32'hF0F0};
    @(negedge clk);
    a = 32'h0F0F; start = 1'b1;
    ctrl = bb_ctrl[0]; b = bb_b[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b%0d valid", i), 32'(valid), 32'd1);
      check($sformatf("b2b%0d ready", i), 32'(ready), 32'd1);
      check($sformatf("b2b%0d out", i), out, bb_exp[i]);
      if (i < 3) begin
        ctrl = bb_ctrl[i+1]; b = bb_b[i+1];
      end else start = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b end valid", 32'(valid), 32'd0);

    // start pulsed while BUSY is ignored; operand changes have no effect.
    @(negedge clk);
    ctrl = 4'd10; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    repeat (4) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; ctrl = 4'd0; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    cyc++;
    start = 1'b0; a = 32'd55; b = 32'd3;
    while (!valid && cyc <= 100) begin @(posedge clk); #1; cyc++; end
    check("busy_ignore latency", 32'(cyc), 32'd33);
    check("busy_ignore out", out, 32'd14);
    nval = 0;
    repeat (3) begin @(posedge clk); #1; if (valid) nval++; end
    check("busy_ignore extra_valid", 32'(nval), 32'd0);

    // Reset asserted in cycle 10 of a DIVU aborts it.
    @(negedge clk);
    ctrl = 4'd10; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst out", out, 32'd0);
    check("midrst zero", 32'(zero), 32'd0);
    check("midrst valid", 32'(valid), 32'd0);
    check("midrst ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    repeat (40) begin @(posedge clk); #1; if (valid) nval++; end
    check("midrst no_valid", 32'(nval), 32'd0);
    run_vec('{"add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b1, 1'b1, 1});

    // WIDTH=8 instance.
    @(negedge clk);
    ctrl8 = 4'd9; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!valid8 && cyc <= 50) begin @(posedge clk); #1; cyc++; end
    check("w8 latency", 32'(cyc), 32'd9);
    check("w8 mulhu out", 32'(out8), 32'hFE);
    check("w8 ready", 32'(ready8), 32'd1);
    check("w8 zero", 32'(zero8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
